mining_job_dispatcher: RTL and testbench
========================================

MINING_JOB_DISPATCHER -- requirements
Module: mining_job_dispatcher

Interface
REQ-001 SHALL have parameters: PIPE_LATENCY, 203, cycles from miner nonce issue to miner valid; FIFO_DEPTH, 4, found-nonce FIFO entries (power of 2).
REQ-002 SHALL have ports: clk input 1, single clock; reset input 1, asynchronous active-low.
REQ-003 SHALL have ports: job_data input 32, job word; job_valid input 1; job_ready output 1; job_abort input 1, abandon current job.
REQ-004 SHALL have ports: version, timestamp, bits output 32 each; prev_block_hash, merkle_root, target output 256 each; all drive miner inputs.
REQ-005 SHALL have ports: miner_reset output 1, active-high hold of miner; miner_valid input 1, miner hit flag.
REQ-006 SHALL have ports: result_nonce output 32; result_valid output 1; result_ready input 1; busy output 1; exhausted output 1; overflow output 1.

Function
REQ-007 SHALL implement states IDLE, LOAD, FLUSH, MINE, DONE.
REQ-008 SHALL accept a job word only when job_valid and job_ready are both 1 on a clk rising edge.
REQ-009 SHALL assert job_ready in IDLE and LOAD only; first accepted word moves IDLE->LOAD.
REQ-010 SHALL take exactly 27 words in order: 0 version; 1-8 prev_block_hash MSW first; 9-16 merkle_root MSW first; 17 timestamp; 18 bits; 19-26 target MSW first.
REQ-011 SHALL move LOAD->FLUSH on acceptance of word 26; miner outputs SHALL update only during LOAD and hold stable otherwise.
REQ-012 SHALL hold miner_reset=1 in IDLE, LOAD, FLUSH, DONE and for exactly 2 cycles of FLUSH, then enter MINE with miner_reset=0.
REQ-013 SHALL run a 33-bit cycle counter in MINE, cleared on MINE entry, incremented each MINE cycle.
REQ-014 SHALL ignore miner_valid while counter < PIPE_LATENCY (pipeline fill).
REQ-015 SHALL, when miner_valid=1 and counter >= PIPE_LATENCY, push nonce = (counter - PIPE_LATENCY) mod 2^32 into the FIFO.
REQ-016 SHALL move MINE->DONE and set exhausted=1 when counter reaches 2^32 + PIPE_LATENCY - 1.
REQ-017 SHALL present FIFO head on result_nonce with result_valid=1 when non-empty; pop when result_valid and result_ready.
REQ-018 SHALL on push to full FIFO with no simultaneous pop drop the nonce and set overflow=1 (sticky until next job start); push+pop on full SHALL succeed without drop.
REQ-019 SHALL allow push+pop on empty FIFO only via storage (no bypass); result appears cycle after push.
REQ-020 SHALL assert busy in LOAD, FLUSH, MINE.
REQ-021 SHALL, on job_abort=1 in any state, go to IDLE next cycle, clear word index, counter, FIFO; abort takes priority over concurrent job handshake.
REQ-022 SHALL in DONE keep FIFO drainable and return to IDLE when FIFO empty; exhausted and overflow clear on next IDLE->LOAD transition.

Reset
REQ-023 SHALL on reset=0 asynchronously enter IDLE, clear counter, word index, FIFO pointers.
REQ-024 SHALL reset outputs: all miner field outputs 0, miner_reset 1, job_ready 0 during reset then 1, result_valid 0, result_nonce 0, busy 0, exhausted 0, overflow 0.
REQ-025 SHALL treat reset mid-LOAD or mid-MINE identically to REQ-023; partial job discarded.

Structure
REQ-026 SHALL place state encoding, JOB_WORDS=27, word-index boundaries and default PIPE_LATENCY in shared defines header with the SHA constants.
REQ-027 SHALL implement FIFO as sub-module nonce_result_fifo (parameter FIFO_DEPTH, 32-bit, valid/ready pop, full/empty flags).

Verification
REQ-028 Load 27 words 0x00000001..0x0000001B -> version=0x1, prev_block_hash MSW=0x2, target LSW=0x1B, state FLUSH, miner_reset low 2 cycles later.
REQ-029 PIPE_LATENCY=8, miner_valid pulse at MINE counter 13 -> result_nonce=5, result_valid=1 next cycle.
REQ-030 miner_valid pulses at counter 3 and 7 with PIPE_LATENCY=8 -> no FIFO push, result_valid stays 0.
REQ-031 FIFO_DEPTH=4, result_ready=0, 5 hits -> 4 entries held, overflow=1, drain order nonces ascending.
REQ-032 job_abort at word 12 of LOAD -> IDLE next cycle, job_ready=1, fresh 27-word load maps word 0 to version.
REQ-033 Force counter near 2^32+PIPE_LATENCY-1 -> exhausted=1, state DONE, return IDLE after FIFO drained; reset=0 mid-MINE -> all REQ-024 values immediately.

Source files
------------

// File: rtl/mining_job_dispatcher_pkg.sv
// Shared definitions for the mining job dispatcher: FSM encoding,
// job word map, default miner latency and SHA-256 initial hash words.
package mining_job_dispatcher_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_FLUSH = 3'd2,
    S_MINE  = 3'd3,
    S_DONE  = 3'd4
  } state_e;

  localparam int unsigned JOB_WORDS        = 27;
  localparam int unsigned DEF_PIPE_LATENCY = 203;
  localparam int unsigned FLUSH_CYCLES     = 2;

  localparam logic [4:0] W_VERSION      = 5'd0;
  localparam logic [4:0] W_PREV_FIRST   = 5'd1;
  localparam logic [4:0] W_PREV_LAST    = 5'd8;
  localparam logic [4:0] W_MERKLE_FIRST = 5'd9;
  localparam logic [4:0] W_MERKLE_LAST  = 5'd16;
  localparam logic [4:0] W_TIME         = 5'd17;
  localparam logic [4:0] W_BITS         = 5'd18;
  localparam logic [4:0] W_TARGET_FIRST = 5'd19;
  localparam logic [4:0] W_TARGET_LAST  = 5'(JOB_WORDS - 1);

  localparam logic [255:0] SHA256_H0 = {
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  // 256-bit fields arrive MSW first, so shifting left lands
  // the first word in the top slot after eight words.
  function automatic logic [255:0] shift_in(
    input logic [255:0] f,
    input logic [31:0]  w
  );
    return {f[223:0], w};
  endfunction

endpackage

// File: rtl/mining_job_dispatcher_fifo.sv
// nonce_result_fifo: 32-bit found-nonce FIFO, push in, valid/ready pop out.
// Ports: clk, rst_n, clr_i, push_i/push_data_i, pop_*, full_o, empty_o.
module nonce_result_fifo #(
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr_i,
  input  logic        push_i,
  input  logic [31:0] push_data_i,
  output logic        pop_valid_o,
  output logic [31:0] pop_data_o,
  input  logic        pop_ready_i,
  output logic        full_o,
  output logic        empty_o
);

  localparam int unsigned AW =
    (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  logic [AW:0]  wr_q, wr_d;
  logic [AW:0]  rd_q, rd_d;
  logic [31:0]  mem_q [FIFO_DEPTH];
  logic         pop;
  logic         wr_en;

  assign empty_o = (wr_q == rd_q);
  assign full_o  = (wr_q[AW] != rd_q[AW]) &&
                   (wr_q[AW-1:0] == rd_q[AW-1:0]);

  assign pop_valid_o = !empty_o;
  assign pop_data_o  = empty_o ? 32'd0 : mem_q[rd_q[AW-1:0]];

  assign pop   = pop_valid_o && pop_ready_i;
  // A pop frees the slot the push is about to fill.
  assign wr_en = push_i && (!full_o || pop);

  always_comb begin
    wr_d = wr_q;
    rd_d = rd_q;
    if (clr_i) begin
      wr_d = '0;
      rd_d = '0;
    end else begin
      if (wr_en) wr_d = wr_q + 1'b1;
      if (pop)   rd_d = rd_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en && !clr_i) mem_q[wr_q[AW-1:0]] <= push_data_i;
  end

endmodule

// File: rtl/mining_job_dispatcher.sv
// Loads a 27-word block header job, runs the miner and queues found nonces.
// Ports: job load handshake, miner fields/reset/hit, result FIFO, status.
module mining_job_dispatcher
  import mining_job_dispatcher_pkg::*;
#(
  parameter int unsigned PIPE_LATENCY = DEF_PIPE_LATENCY,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [31:0]  job_data,
  input  logic         job_valid,
  output logic         job_ready,
  input  logic         job_abort,
  output logic [31:0]  version,
  output logic [31:0]  timestamp,
  output logic [31:0]  bits,
  output logic [255:0] prev_block_hash,
  output logic [255:0] merkle_root,
  output logic [255:0] target,
  output logic         miner_reset,
  input  logic         miner_valid,
  output logic [31:0]  result_nonce,
  output logic         result_valid,
  input  logic         result_ready,
  output logic         busy,
  output logic         exhausted,
  output logic         overflow
);

  localparam logic [32:0] PL33     = 33'(PIPE_LATENCY);
  localparam logic [32:0] CNT_LAST = 33'h1_0000_0000 + PL33 - 33'd1;
  localparam logic [1:0]  FL_LAST  = 2'(FLUSH_CYCLES - 1);

  state_e       state_q, state_d;
  logic [4:0]   widx_q, widx_d;
  logic [32:0]  cnt_q, cnt_d;
  logic [1:0]   fl_q, fl_d;
  logic         exh_q, exh_d;
  logic         ovf_q, ovf_d;

  logic [31:0]  version_q, time_q, bits_q;
  logic [255:0] prev_q, merkle_q, target_q;

  logic         accept;
  logic         push;
  logic         pop;
  logic         fifo_clr;
  logic         fifo_full;
  logic         fifo_empty;
  logic [31:0]  nonce;

  // Abort wins over a concurrent handshake.
  assign accept = job_valid && job_ready && !job_abort;
  assign push   = (state_q == S_MINE) && miner_valid &&
                  (cnt_q >= PL33);
  assign pop    = result_valid && result_ready;
  assign nonce  = cnt_q[31:0] - PL33[31:0];

  always_comb begin
    state_d  = state_q;
    widx_d   = widx_q;
    cnt_d    = cnt_q;
    fl_d     = fl_q;
    exh_d    = exh_q;
    ovf_d    = ovf_q;
    fifo_clr = 1'b0;
    if (job_abort) begin
      state_d  = S_IDLE;
      widx_d   = '0;
      cnt_d    = '0;
      fl_d     = '0;
      fifo_clr = 1'b1;
    end else begin
      if (push && fifo_full && !pop) ovf_d = 1'b1;
      unique case (state_q)
        S_IDLE: begin
          if (accept) begin
            state_d = S_LOAD;
            widx_d  = 5'd1;
            exh_d   = 1'b0;
            ovf_d   = 1'b0;
          end
        end
        S_LOAD: begin
          if (accept) begin
            if (widx_q == W_TARGET_LAST) begin
              state_d = S_FLUSH;
              widx_d  = '0;
              fl_d    = '0;
            end else begin
              widx_d = widx_q + 5'd1;
            end
          end
        end
        S_FLUSH: begin
          if (fl_q == FL_LAST) begin
            state_d = S_MINE;
            cnt_d   = '0;
            fl_d    = '0;
          end else begin
            fl_d = fl_q + 2'd1;
          end
        end
        S_MINE: begin
          if (cnt_q == CNT_LAST) begin
            state_d = S_DONE;
            exh_d   = 1'b1;
          end else begin
            cnt_d = cnt_q + 33'd1;
          end
        end
        S_DONE: begin
          if (fifo_empty) state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      widx_q  <= '0;
      cnt_q   <= '0;
      fl_q    <= '0;
      exh_q   <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      widx_q  <= widx_d;
      cnt_q   <= cnt_d;
      fl_q    <= fl_d;
      exh_q   <= exh_d;
      ovf_q   <= ovf_d;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      version_q <= '0;
      time_q    <= '0;
      bits_q    <= '0;
      prev_q    <= '0;
      merkle_q  <= '0;
      target_q  <= '0;
    end else if (accept) begin
      unique case (1'b1)
        (widx_q == W_VERSION):
          version_q <= job_data;
        (widx_q >= W_PREV_FIRST && widx_q <= W_PREV_LAST):
          prev_q <= shift_in(prev_q, job_data);
        (widx_q >= W_MERKLE_FIRST && widx_q <= W_MERKLE_LAST):
          merkle_q <= shift_in(merkle_q, job_data);
        (widx_q == W_TIME):
          time_q <= job_data;
        (widx_q == W_BITS):
          bits_q <= job_data;
        (widx_q >= W_TARGET_FIRST && widx_q <= W_TARGET_LAST):
          target_q <= shift_in(target_q, job_data);
        default: ;
      endcase
    end
  end

  nonce_result_fifo #(
    .FIFO_DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst_n      (reset),
    .clr_i      (fifo_clr),
    .push_i     (push),
    .push_data_i(nonce),
    .pop_valid_o(result_valid),
    .pop_data_o (result_nonce),
    .pop_ready_i(result_ready),
    .full_o     (fifo_full),
    .empty_o    (fifo_empty)
  );

  assign version         = version_q;
  assign timestamp       = time_q;
  assign bits            = bits_q;
  assign prev_block_hash = prev_q;
  assign merkle_root     = merkle_q;
  assign target          = target_q;

  // Ready is held low while reset is asserted.
  assign job_ready   = reset &&
                       (state_q == S_IDLE || state_q == S_LOAD);
  assign miner_reset = (state_q != S_MINE);
  assign busy        = (state_q == S_LOAD) || (state_q == S_FLUSH) ||
                       (state_q == S_MINE);
  assign exhausted   = exh_q;
  assign overflow    = ovf_q;

endmodule

// File: tb/tb_mining_job_dispatcher.sv
// Directed bench for mining_job_dispatcher with a nonce scoreboard.
// Runs with PIPE_LATENCY=8 and FIFO_DEPTH=4.
module tb_mining_job_dispatcher;
  import mining_job_dispatcher_pkg::*;

  localparam longint unsigned PL    = 8;
  localparam int unsigned     DEPTH = 4;
  localparam logic [32:0]     LIMIT = 33'h1_0000_0007;

  logic         clk = 1'b0;
  logic         reset;
  logic [31:0]  job_data;
  logic         job_valid;
  logic         job_ready;
  logic         job_abort;
  logic [31:0]  version, timestamp, bits;
  logic [255:0] prev_block_hash, merkle_root, target;
  logic         miner_reset;
  logic         miner_valid;
  logic [31:0]  result_nonce;
  logic         result_valid;
  logic         result_ready;
  logic         busy, exhausted, overflow;

  int              n_cmp = 0;
  int              n_err = 0;
  logic [31:0]     q[$];
  logic [31:0]     tmp;
  longint unsigned mc;
  bit              exp_ovf;

  mining_job_dispatcher #(
    .PIPE_LATENCY(8),
    .FIFO_DEPTH  (4)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .job_data       (job_data),
    .job_valid      (job_valid),
    .job_ready      (job_ready),
    .job_abort      (job_abort),
    .version        (version),
    .timestamp      (timestamp),
    .bits           (bits),
    .prev_block_hash(prev_block_hash),
    .merkle_root    (merkle_root),
    .target         (target),
    .miner_reset    (miner_reset),
    .miner_valid    (miner_valid),
    .result_nonce   (result_nonce),
    .result_valid   (result_valid),
    .result_ready   (result_ready),
    .busy           (busy),
    .exhausted      (exhausted),
    .overflow       (overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [255:0] obs,
                     input logic [255:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    mc++;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic chk_head(input string tag);
    if (q.size() > 0) begin
      chk({tag, "_rv"}, 256'(result_valid), 256'd1);
      chk({tag, "_nonce"}, 256'(result_nonce), 256'(q[0]));
    end else begin
      chk({tag, "_rv"}, 256'(result_valid), 256'd0);
    end
  endtask

  task automatic load(input logic [31:0] base, input int n);
    for (int i = 0; i < n; i++) begin
      job_valid = 1'b1;
      job_data  = base + 32'(i);
      step();
    end
    job_valid = 1'b0;
  endtask

  task automatic hit(input bit do_pop);
    miner_valid  = 1'b1;
    result_ready = do_pop;
    if (do_pop) begin
      chk_head("pushpop");
      tmp = q.pop_front();
    end
    if (mc >= PL) begin
      if (q.size() < DEPTH) q.push_back(32'(mc - PL));
      else exp_ovf = 1'b1;
    end
    step();
    miner_valid  = 1'b0;
    result_ready = 1'b0;
  endtask

  task automatic drain();
    while (q.size() > 0) begin
      result_ready = 1'b1;
      chk_head("drain");
      tmp = q.pop_front();
      step();
    end
    result_ready = 1'b0;
    chk("drain_empty", 256'(result_valid), 256'd0);
  endtask

  initial begin
    reset        = 1'b0;
    job_data     = '0;
    job_valid    = 1'b0;
    job_abort    = 1'b0;
    miner_valid  = 1'b0;
    result_ready = 1'b0;
    mc           = 0;
    exp_ovf      = 1'b0;

    #3;
    chk("rst_jrdy", 256'(job_ready), 256'd0);
    chk("rst_mrst", 256'(miner_reset), 256'd1);
    chk("rst_rv", 256'(result_valid), 256'd0);
    chk("rst_nonce", 256'(result_nonce), 256'd0);
    chk("rst_busy", 256'(busy), 256'd0);
    chk("rst_exh", 256'(exhausted), 256'd0);
    chk("rst_ovf", 256'(overflow), 256'd0);
    chk("rst_ver", 256'(version), 256'd0);
    chk("rst_tgt", target, 256'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    chk("rel_jrdy", 256'(job_ready), 256'd1);

    load(32'h1, 27);
    chk("ld_ver", 256'(version), 256'h1);
    chk("ld_prev_msw", 256'(prev_block_hash[255:224]), 256'h2);
    chk("ld_prev_lsw", 256'(prev_block_hash[31:0]), 256'h9);
    chk("ld_mrk_msw", 256'(merkle_root[255:224]), 256'hA);
    chk("ld_time", 256'(timestamp), 256'h12);
    chk("ld_bits", 256'(bits), 256'h13);
    chk("ld_tgt_msw", 256'(target[255:224]), 256'h14);
    chk("ld_tgt_lsw", 256'(target[31:0]), 256'h1B);
    chk("ld_state", 256'(dut.state_q), 256'(S_FLUSH));
    chk("ld_busy", 256'(busy), 256'd1);
    chk("ld_jrdy", 256'(job_ready), 256'd0);

    job_valid = 1'b1;
    job_data  = 32'hFFFF;
    step();
    job_valid = 1'b0;
    chk("fl1_ver_hold", 256'(version), 256'h1);
    chk("fl1_mrst", 256'(miner_reset), 256'd1);
    step();
    chk("fl2_mrst", 256'(miner_reset), 256'd0);
    chk("fl2_state", 256'(dut.state_q), 256'(S_MINE));
    mc = 0;

    steps(3);
    hit(1'b0);
    steps(3);
    hit(1'b0);
    chk_head("fill_ignored");
    steps(5);
    hit(1'b0);
    chk_head("first_hit");
    drain();

    for (int i = 0; i < 5; i++) hit(1'b0);
    chk("ovf_set", 256'(overflow), 256'(exp_ovf));
    chk_head("ovf_head");
    drain();

    for (int i = 0; i < 4; i++) hit(1'b0);
    hit(1'b1);
    chk("full_pp_ovf", 256'(overflow), 256'(exp_ovf));
    drain();

    force dut.cnt_q = LIMIT - 33'd2;
    #1;
    release dut.cnt_q;
    mc = longint'(LIMIT) - 2;
    step();
    chk("pre_exh", 256'(exhausted), 256'd0);
    chk("pre_exh_st", 256'(dut.state_q), 256'(S_MINE));
    step();
    hit(1'b0);
    chk("exh", 256'(exhausted), 256'd1);
    chk("exh_state", 256'(dut.state_q), 256'(S_DONE));
    chk("exh_busy", 256'(busy), 256'd0);
    chk_head("last_nonce");
    drain();
    chk("done_hold", 256'(dut.state_q), 256'(S_DONE));
    step();
    chk("done_idle", 256'(dut.state_q), 256'(S_IDLE));
    chk("idle_exh", 256'(exhausted), 256'd1);

    load(32'h100, 12);
    exp_ovf = 1'b0;
    chk("ld2_exh_clr", 256'(exhausted), 256'd0);
    chk("ld2_ovf_clr", 256'(overflow), 256'(exp_ovf));
    chk("ld2_state", 256'(dut.state_q), 256'(S_LOAD));
    job_valid = 1'b1;
    job_data  = 32'hDEAD;
    job_abort = 1'b1;
    step();
    job_abort = 1'b0;
    job_valid = 1'b0;
    chk("abort_state", 256'(dut.state_q), 256'(S_IDLE));
    chk("abort_jrdy", 256'(job_ready), 256'd1);
    chk("abort_busy", 256'(busy), 256'd0);

    load(32'h100, 27);
    chk("ld3_ver", 256'(version), 256'h100);
    chk("ld3_prev_msw", 256'(prev_block_hash[255:224]), 256'h101);
    chk("ld3_time", 256'(timestamp), 256'h111);
    chk("ld3_tgt_lsw", 256'(target[31:0]), 256'h11A);
    chk("ld3_state", 256'(dut.state_q), 256'(S_FLUSH));
    steps(2);
    mc = 0;
    steps(10);
    for (int i = 0; i < 5; i++) hit(1'b0);
    chk("m3_ovf", 256'(overflow), 256'(exp_ovf));
    chk_head("m3_head");

    #2;
    reset = 1'b0;
    #1;
    q.delete();
    exp_ovf = 1'b0;
    chk("mr_ver", 256'(version), 256'd0);
    chk("mr_prev", prev_block_hash, 256'd0);
    chk("mr_tgt", target, 256'd0);
    chk("mr_mrst", 256'(miner_reset), 256'd1);
    chk("mr_jrdy", 256'(job_ready), 256'd0);
    chk("mr_rv", 256'(result_valid), 256'd0);
    chk("mr_nonce", 256'(result_nonce), 256'd0);
    chk("mr_busy", 256'(busy), 256'd0);
    chk("mr_exh", 256'(exhausted), 256'd0);
    chk("mr_ovf", 256'(overflow), 256'(exp_ovf));
    #2;
    reset = 1'b1;
    step();
    chk("post_state", 256'(dut.state_q), 256'(S_IDLE));
    chk("post_jrdy", 256'(job_ready), 256'd1);
    chk_head("post_rv");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
